// File: rtl/serial_to_parallel_framed.sv
// Framed serial-to-parallel assembler: LANES bits per beat into WIDTH-bit words
// behind a VALID/READY holding register. Optional parity check via S2P_PARITY_EN.
module serial_to_parallel_framed #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [LANES-1:0] DATA_IN,
    input  logic             EN,
    input  logic             START,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    input  logic             READY,
    output logic             BUSY,
    output logic             OVERRUN,
`ifdef S2P_PARITY_EN
    input  logic             PARITY_IN,
    output logic             PARITY_ERR,
`endif
    input  logic             CLR_OVERRUN
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef S2P_PARITY_EN
    // Even parity expected over word plus parity bit; 1 flags an error.
    function automatic logic even_par_err(input logic [WIDTH-1:0] w, input logic p);
        return (^w) ^ p;
    endfunction
`endif

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] sr_base_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic [WIDTH-1:0] shifted_s;
    logic             complete_s;
    logic             accept_s;
    logic             drop_s;
`ifdef S2P_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // Shift/count next state; START zeroes the partial word before this beat lands.
    always_comb begin
        sr_base_s  = sr_q;
        cnt_base_s = cnt_q;
        shifted_s  = sr_q;
        complete_s = 1'b0;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        if (START) begin
            sr_base_s  = {WIDTH{1'b0}};
            cnt_base_s = CNT_ZERO;
        end else begin
            sr_base_s  = sr_q;
            cnt_base_s = cnt_q;
        end
        // Whole-vector shifts also cover LANES == WIDTH (shift-out yields zero).
        if (MSB_FIRST != 0) begin
            shifted_s = (sr_base_s << LANES) | WIDTH'(DATA_IN);
        end else begin
            shifted_s = (sr_base_s >> LANES) | (WIDTH'(DATA_IN) << (WIDTH - LANES));
        end
        if (EN) begin
            sr_d = shifted_s;
            if (cnt_base_s == CNT_LAST) begin
                complete_s = 1'b1;
                cnt_d      = CNT_ZERO;
            end else begin
                complete_s = 1'b0;
                cnt_d      = cnt_base_s + CNT_ONE;
            end
        end else if (START) begin
            sr_d  = {WIDTH{1'b0}};
            cnt_d = CNT_ZERO;
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Holding register, handshake and sticky overrun next state.
    always_comb begin
        accept_s  = complete_s & (~valid_q | READY);
        drop_s    = complete_s & valid_q & ~READY;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
`ifdef S2P_PARITY_EN
        perr_d    = perr_q;
`endif
        if (accept_s) begin
            data_d  = shifted_s;
            valid_d = 1'b1;
`ifdef S2P_PARITY_EN
            perr_d  = even_par_err(shifted_s, PARITY_IN);
`endif
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (CLR_OVERRUN) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sr_q      <= {WIDTH{1'b0}};
            cnt_q     <= CNT_ZERO;
            data_q    <= {WIDTH{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef S2P_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef S2P_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign DATA    = data_q;
    assign VALID   = valid_q;
    assign OVERRUN = overrun_q;
    assign BUSY    = (cnt_q != CNT_ZERO);
`ifdef S2P_PARITY_EN
    assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_framed.sv
// Bench for serial_to_parallel_framed (WIDTH=8, LANES=2), MSB- and LSB-first
// instances on shared stimulus, checked every cycle against a beat-list model.
module tb_serial_to_parallel_framed;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] din = 2'b11;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] d_msb, d_lsb;
    logic       v_msb, v_lsb, b_msb, b_lsb, o_msb, o_lsb;
`ifdef S2P_PARITY_EN
    logic       par = 1'b0;
    logic       pe_msb, pe_lsb;
    logic       m_perr = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic [1:0] mq[$];
    logic [7:0] m_msb = 8'h00;
    logic [7:0] m_lsb = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_over = 1'b0;

    always #5 clk = ~clk;

    serial_to_parallel_framed #(.WIDTH(8), .LANES(2), .MSB_FIRST(1)) u_msb (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din), .EN(en), .START(start),
        .DATA(d_msb), .VALID(v_msb), .READY(ready), .BUSY(b_msb), .OVERRUN(o_msb),
`ifdef S2P_PARITY_EN
        .PARITY_IN(par), .PARITY_ERR(pe_msb),
`endif
        .CLR_OVERRUN(clr));

    serial_to_parallel_framed #(.WIDTH(8), .LANES(2), .MSB_FIRST(0)) u_lsb (
        .CLK(clk), .RST_N(rst_n), .DATA_IN(din), .EN(en), .START(start),
        .DATA(d_lsb), .VALID(v_lsb), .READY(ready), .BUSY(b_lsb), .OVERRUN(o_lsb),
`ifdef S2P_PARITY_EN
        .PARITY_IN(par), .PARITY_ERR(pe_lsb),
`endif
        .CLR_OVERRUN(clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: collect beats in a list; on the 4th, build the word by positional arithmetic.
    initial begin
        logic [7:0] w_msb, w_lsb;
        logic       comp, drop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_msb = 8'h00; m_lsb = 8'h00; m_valid = 1'b0; m_over = 1'b0;
`ifdef S2P_PARITY_EN
                m_perr = 1'b0;
`endif
            end else begin
                comp = 1'b0; w_msb = 8'h00; w_lsb = 8'h00;
                if (start) mq.delete();
                if (en) begin
                    mq.push_back(din);
                    if (mq.size() == 4) begin
                        for (int i = 0; i < 4; i++) begin
                            w_msb = w_msb | (8'(mq[i]) << (2 * (3 - i)));
                            w_lsb = w_lsb | (8'(mq[i]) << (2 * i));
                        end
                        comp = 1'b1;
                        mq.delete();
                    end
                end
                drop = comp && m_valid && !ready;
                if (comp && !drop) begin
                    m_msb = w_msb; m_lsb = w_lsb; m_valid = 1'b1;
`ifdef S2P_PARITY_EN
                    m_perr = (^w_msb) ^ par;
`endif
                end else if (!comp && m_valid && ready) begin
                    m_valid = 1'b0;
                end
                if (drop) m_over = 1'b1;
                else if (clr) m_over = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("data_msb", d_msb, m_msb);
            chk("data_lsb", d_lsb, m_lsb);
            chk("valid_msb", v_msb, m_valid);
            chk("valid_lsb", v_lsb, m_valid);
            chk("busy_msb", b_msb, mq.size() != 0);
            chk("busy_lsb", b_lsb, mq.size() != 0);
            chk("overrun_msb", o_msb, m_over);
            chk("overrun_lsb", o_lsb, m_over);
`ifdef S2P_PARITY_EN
            chk("perr_msb", pe_msb, m_perr);
            chk("perr_lsb", pe_lsb, m_perr);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] d, input logic s);
        en = 1'b1; din = d; start = s;
        tick();
        en = 1'b0; start = 1'b0; din = 2'b11;
    endtask

    task automatic word4(input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
        beat(a, 1'b0); beat(b, 1'b0); beat(c, 1'b0); beat(d, 1'b0);
    endtask

    initial begin
        // Reset and idle with EN low
        repeat (2) tick();
        chk("rst_data", d_msb, 8'h00);
        chk("rst_valid", v_msb, 1'b0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_data", d_msb, 8'h00);
        chk("idle_busy", b_msb, 1'b0);

        // Assembly in both orders, READY low
        beat(2'b01, 1'b0);
        chk("busy_b1", b_msb, 1'b1);
        beat(2'b10, 1'b0);
        beat(2'b11, 1'b0);
        chk("busy_b3", b_msb, 1'b1);
        chk("valid_b3", v_msb, 1'b0);
        beat(2'b00, 1'b0);
        chk("word_msb", d_msb, 8'h6C);
        chk("word_lsb", d_lsb, 8'h39);
        chk("valid_b4", v_msb, 1'b1);
        chk("busy_b4", b_msb, 1'b0);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("consumed_valid", v_msb, 1'b0);
        chk("consumed_data", d_msb, 8'h6C);

        // Overrun and clear
        word4(2'b01, 2'b10, 2'b11, 2'b00);
        word4(2'b11, 2'b11, 2'b11, 2'b11);
        chk("ovr_data", d_msb, 8'h6C);
        chk("ovr_flag", o_msb, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovr_clr", o_msb, 1'b0);

        // Back-to-back completion with READY high on the completing edge
        beat(2'b11, 1'b0); beat(2'b11, 1'b0); beat(2'b11, 1'b0);
        ready = 1'b1; beat(2'b11, 1'b0); ready = 1'b0;
        chk("b2b_data", d_msb, 8'hFF);
        chk("b2b_valid", v_msb, 1'b1);
        chk("b2b_ovr", o_msb, 1'b0);
        ready = 1'b1; tick(); ready = 1'b0;

        // START with EN low discards a partial word
        beat(2'b11, 1'b0); beat(2'b11, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy", b_msb, 1'b0);
        word4(2'b01, 2'b10, 2'b11, 2'b00);
        chk("start_word", d_msb, 8'h6C);
        ready = 1'b1; tick(); ready = 1'b0;

        // START with EN high makes this beat beat 0
        beat(2'b11, 1'b0);
        beat(2'b01, 1'b1);
        chk("starten_busy", b_msb, 1'b1);
        beat(2'b10, 1'b0); beat(2'b11, 1'b0); beat(2'b00, 1'b0);
        chk("starten_msb", d_msb, 8'h6C);
        chk("starten_lsb", d_lsb, 8'h39);

        // Asynchronous reset mid-word
        beat(2'b10, 1'b0); beat(2'b10, 1'b0); beat(2'b10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", d_msb, 8'h00);
        chk("arst_valid", v_msb, 1'b0);
        chk("arst_busy", b_msb, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef S2P_PARITY_EN
        // Parity flag travels with the accepted word
        beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0);
        par = 1'b0; beat(2'b00, 1'b0);
        chk("par_ok", pe_msb, 1'b0);
        ready = 1'b1; tick(); ready = 1'b0;
        beat(2'b01, 1'b0); beat(2'b10, 1'b0); beat(2'b11, 1'b0);
        par = 1'b1; beat(2'b00, 1'b0); par = 1'b0;
        chk("par_err", pe_msb, 1'b1);
        chk("par_valid", v_msb, 1'b1);
        chk("par_data", d_msb, 8'h6C);
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_framed.md
Name: serial_to_parallel_framed

Overview:
Parametrised successor to the single-bit serial-to-parallel shifter. It accepts LANES bits per enabled cycle and assembles them into WIDTH-bit words, with a selectable shift order and a frame-sync input. Each completed word is presented on a holding register with a VALID/READY handshake, and lost words are flagged.
It sits between the serial cell-row loader and the board memory write path.

Parameters:
WIDTH, 8, assembled word width in bits; must be a multiple of LANES.
LANES, 1, serial bits accepted per enabled cycle; 1 <= LANES <= WIDTH.
MSB_FIRST, 1, 1 = first beat ends in the top bits; 0 = first beat ends in the bottom bits.

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous, active-low reset
DATA_IN  input  LANES  serial beat; bit 0 is the least significant bit of the beat
EN  input  1  beat strobe; DATA_IN is captured on the edge where EN=1
START  input  1  frame sync; discards any partial word
DATA  output  WIDTH  completed word (holding register)
VALID  output  1  DATA holds an unconsumed word
READY  input  1  consumer accepts DATA on the edge where VALID&READY
BUSY  output  1  partial word in progress (beat count != 0)
OVERRUN  output  1  sticky flag: a completed word was dropped
CLR_OVERRUN  input  1  synchronous clear of OVERRUN

Behaviour:
- BEATS = WIDTH/LANES. Internal state:
  - shift register SR[WIDTH-1:0]
  - beat counter CNT, width $clog2(BEATS) with a minimum of 1, range 0..BEATS-1
- Reset (RST_N=0, asynchronous): SR=0, CNT=0, DATA=0, VALID=0, OVERRUN=0, BUSY=0. Reset is honoured mid-word and mid-handshake; the partial word is discarded.
- Shift on an edge with EN=1:
  - MSB_FIRST=1: SR <= {SR[WIDTH-LANES-1:0], DATA_IN}.
  - MSB_FIRST=0: SR <= {DATA_IN, SR[WIDTH-1:LANES]}.
  - With LANES=WIDTH, SR <= DATA_IN in both modes.
- Counting: each EN beat increments CNT. On the beat where CNT==BEATS-1, CNT wraps to 0 and the word completes.
- Completion uses the shifted value including the final beat (W). On the same edge:
  - If VALID=0 or READY=1: DATA<=W and VALID<=1. Zero extra latency.
  - Else (VALID=1 and READY=0): W is dropped, DATA is unchanged, and OVERRUN<=1.
- Handshake:
  - VALID&READY with no completion on that edge: VALID<=0, DATA holds its value.
  - DATA never changes while VALID=1 && READY=0.
- START:
  - With EN=0: CNT<=0 and SR<=0.
  - With EN=1: the partial word is discarded, and this beat is beat 0. The shift is applied to a zeroed SR and CNT<=1; if BEATS==1, the word completes normally.
  - START has no effect on DATA, VALID or OVERRUN.
- BUSY = (CNT != 0). This is combinational from the register.
- OVERRUN:
  - Set has priority over CLR_OVERRUN on the same edge.
  - Otherwise CLR_OVERRUN=1 clears it.
- EN=0 cycles do not change SR or CNT; gaps between beats are allowed indefinitely.

Optional Feature:
Macro S2P_PARITY_EN.
- Defined:
  - Adds input PARITY_IN (1 bit), sampled only on the completing beat.
  - Adds output PARITY_ERR (1 bit), written together with DATA on each accepted completion. Value is 1 when the XOR of W and PARITY_IN is 1 (even parity expected).
  - PARITY_ERR resets to 0 and holds with DATA. A dropped word does not update it.
- Not defined: neither port exists and no parity logic is built.

Test Plan:
All scenarios use WIDTH=8 and LANES=2 unless stated.
1. Reset/idle: RST_N=0 then release; hold EN=0 with DATA_IN=2'b11 for 5 cycles -> DATA=0, VALID=0, BUSY=0 throughout.
2. MSB_FIRST=1 assembly: beats 01,10,11,00 with READY=0 -> VALID rises on the 4th EN edge, DATA=8'h6C. BUSY is 1 after beats 1-3 and 0 after beat 4. Assert READY for 1 cycle -> VALID=0, DATA stays 8'h6C.
3. MSB_FIRST=0 assembly: same beats -> DATA=8'h39, VALID=1.
4. Overrun: READY=0; send two full words (8'h6C, then 8'hFF) -> DATA=8'h6C, OVERRUN=1. Pulse CLR_OVERRUN -> OVERRUN=0. Back-to-back completion with READY=1 -> DATA updates and VALID stays 1.
5. START/reset mid-word: send 2 beats, then pulse START with EN=0, then send 01,10,11,00 -> DATA=8'h6C. Next, send 3 beats and drop RST_N mid-cycle -> SR, CNT, VALID and DATA read 0 immediately.
6. Parity (S2P_PARITY_EN defined): word 8'h6C with PARITY_IN=0 -> PARITY_ERR=0. Same word with PARITY_IN=1 -> PARITY_ERR=1, and the word is still delivered.
